// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline types, access-size codes and byte-lane helpers
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2,
        DERR  = 2'd3
    } arb_state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Lanes touched by an access; size code 3 behaves as a full word.
    function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] addr_lo);
        case (sz)
            SZ_BYTE: byte_en = 4'b0001 << addr_lo;
            SZ_HALF: byte_en = 4'b0011 << {addr_lo[1], 1'b0};
            default: byte_en = 4'b1111;
        endcase
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one; size 3 is never flagged.
    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] addr_lo);
        misaligned = ((sz == SZ_HALF) && addr_lo[0]) ||
                     ((sz == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the external memory bus between fetch and data ports
module mem_port_arbiter
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT      = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_sz,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_kill,
    output logic        i_ack,
    output logic        i_err,
    output logic [31:0] i_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int ST_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT - 1);
    localparam logic [ST_W-1:0] ST_MAX    = ST_W'(STARVE_LIMIT);
    localparam logic [31:0]     WORD_MASK = 32'hFFFF_FFFC;

    arb_state_t       state, state_n;
    logic [WD_W-1:0]  wdog, wdog_n;
    logic [ST_W-1:0]  starve, starve_n;
    logic             kill, kill_n;
    logic             bus_req_n, bus_we_n;
    logic [31:0]      bus_addr_n, bus_wdata_n;
    logic [3:0]       bus_be_n;

    logic fetch_ok;
    logic wd_tc;
    logic done;
    logic in_data;
    logic in_fetch;
    logic i_live;

    // A fetch only competes when it has not been abandoned this cycle.
    assign fetch_ok = i_req && !i_kill;
    assign wd_tc    = (wdog == WD_LAST);
    assign done     = bus_ack || wd_tc;
    assign in_data  = (state == DATA);
    assign in_fetch = (state == FETCH);
    // A killed fetch still owns the bus until it finishes, but reports nothing.
    assign i_live   = in_fetch && !kill && !i_kill;

    assign d_ack   = (state == DERR) || (in_data && done);
    assign d_err   = (state == DERR) || (in_data && !bus_ack && wd_tc);
    assign d_rdata = (in_data && bus_ack) ? bus_rdata : '0;
    assign i_ack   = i_live && done;
    assign i_err   = i_live && !bus_ack && wd_tc;
    assign i_rdata = (i_live && bus_ack) ? bus_rdata : '0;

    // Next-state, arbitration and bus-cycle launch/termination.
    always_comb begin
        state_n     = state;
        wdog_n      = wdog;
        starve_n    = starve;
        kill_n      = kill;
        bus_req_n   = bus_req;
        bus_we_n    = bus_we;
        bus_addr_n  = bus_addr;
        bus_be_n    = bus_be;
        bus_wdata_n = bus_wdata;

        case (state)
            IDLE: begin
                wdog_n = '0;
                kill_n = 1'b0;
                if (d_req && misaligned(d_sz, d_addr[1:0])) begin
                    state_n = DERR;
                end else if (d_req && !(fetch_ok && (starve == ST_MAX))) begin
                    state_n     = DATA;
                    bus_req_n   = 1'b1;
                    bus_we_n    = d_we;
                    bus_addr_n  = d_addr & WORD_MASK;
                    bus_be_n    = byte_en(d_sz, d_addr[1:0]);
                    bus_wdata_n = d_wdata;
                    starve_n    = fetch_ok ? starve + 1'b1 : '0;
                end else if (fetch_ok) begin
                    state_n     = FETCH;
                    bus_req_n   = 1'b1;
                    bus_we_n    = 1'b0;
                    bus_addr_n  = i_addr & WORD_MASK;
                    bus_be_n    = 4'b1111;
                    bus_wdata_n = '0;
                    starve_n    = '0;
                end
            end
            DATA, FETCH: begin
                if (in_fetch && i_kill) begin
                    kill_n = 1'b1;
                end
                if (done) begin
                    state_n   = IDLE;
                    bus_req_n = 1'b0;
                    wdog_n    = '0;
                end else begin
                    wdog_n = wdog + 1'b1;
                end
            end
            DERR: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, bus outputs and counters; reset abandons any bus cycle in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wdog      <= '0;
            starve    <= '0;
            kill      <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
        end else begin
            state     <= state_n;
            wdog      <= wdog_n;
            starve    <= starve_n;
            kill      <= kill_n;
            bus_req   <= bus_req_n;
            bus_we    <= bus_we_n;
            bus_addr  <= bus_addr_n;
            bus_be    <= bus_be_n;
            bus_wdata <= bus_wdata_n;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int TO = 8;
    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_req, d_we;
    logic [1:0]  d_sz;
    logic [31:0] d_addr, d_wdata;
    logic        d_ack, d_err;
    logic [31:0] d_rdata;
    logic        i_req, i_kill;
    logic [31:0] i_addr;
    logic        i_ack, i_err;
    logic [31:0] i_rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int vectors = 0;
    int miscompares = 0;

    mem_port_arbiter #(.TIMEOUT(TO), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .d_req(d_req), .d_we(d_we), .d_sz(d_sz), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill),
        .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    function automatic int size_bytes(input bit is_data, input logic [1:0] sz);
        if (!is_data) return 4;
        if (sz == 2'd0) return 1;
        if (sz == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] model_be(input bit is_data, input logic [1:0] sz,
                                            input logic [31:0] addr);
        int n, start;
        logic [3:0] be;
        n = size_bytes(is_data, sz);
        start = (int'(addr & 32'd3) / n) * n;
        be = 4'b0000;
        for (int lane = 0; lane < 4; lane++) be[lane] = (lane >= start) && (lane < start + n);
        return be;
    endfunction

    function automatic bit model_misaligned(input logic [1:0] sz, input logic [31:0] addr);
        return ((sz == 2'd1) && (addr % 2 != 0)) || ((sz == 2'd2) && (addr % 4 != 0));
    endfunction

    task automatic check_quiet(input string tag);
        chk({tag, "_busreq"}, bus_req, 0);
        chk({tag, "_acks"}, {d_ack, d_err, i_ack, i_err}, 0);
    endtask

    task automatic do_access(input bit is_data, input bit we, input logic [1:0] sz,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int ack_at, input logic [31:0] rdata, input int kill_at);
        bit mis, timed_out, killed, last;
        int term;
        logic [3:0] be;
        mis = is_data && model_misaligned(sz, addr);
        be = model_be(is_data, sz, addr);
        timed_out = (ack_at > TO - 1);
        term = timed_out ? TO - 1 : ack_at;
        killed = !is_data && (kill_at >= 0) && (kill_at <= term);

        if (is_data) begin
            d_req = 1'b1; d_we = we; d_sz = sz; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        bus_ack = 1'b0;
        bus_rdata = $urandom;
        at_neg();
        check_quiet("grant_cycle");
        tick();

        if (mis) begin
            bus_ack = 1'b1;
            bus_rdata = $urandom;
            at_neg();
            chk("derr_ack", d_ack, 1);
            chk("derr_err", d_err, 1);
            chk("derr_busreq", bus_req, 0);
            chk("derr_rdata", d_rdata, 0);
            d_req = 1'b0;
            bus_ack = 1'b0;
            tick();
            at_neg();
            check_quiet("after_derr");
            tick();
            return;
        end

        for (int idx = 0; idx <= term; idx++) begin
            bus_ack = (idx == ack_at);
            bus_rdata = (idx == ack_at) ? rdata : $urandom;
            i_kill = (idx == kill_at);
            if (!is_data && kill_at >= 0 && idx > kill_at) i_req = 1'b0;
            last = (idx == term);
            at_neg();
            chk("bus_req", bus_req, 1);
            chk("bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
            chk("bus_be", bus_be, be);
            chk("bus_we", bus_we, is_data && we);
            if (is_data) chk("bus_wdata", bus_wdata, wdata);
            chk("d_ack", d_ack, is_data && last);
            chk("d_err", d_err, is_data && last && timed_out);
            chk("d_rdata", d_rdata, (is_data && last && !timed_out) ? rdata : 32'h0);
            chk("i_ack", i_ack, !is_data && last && !killed);
            chk("i_err", i_err, !is_data && last && !killed && timed_out);
            chk("i_rdata", i_rdata, (!is_data && last && !killed && !timed_out) ? rdata : 32'h0);
            tick();
        end

        d_req = 1'b0; i_req = 1'b0; i_kill = 1'b0; bus_ack = 1'b0;
        at_neg();
        check_quiet("after_access");
        tick();
    endtask

    task automatic contention(input int n, input bit rnd);
        string exp_str;
        int starve_m;
        bit dp, ip, exp_d;
        exp_str = "DDDDFDDDDF";
        starve_m = 0;
        dp = 1'b0;
        ip = 1'b0;
        for (int g = 0; g < n; g++) begin
            if (rnd) begin
                if (!dp) dp = $urandom_range(0, 1);
                if (!ip) ip = $urandom_range(0, 1);
                if (!dp && !ip) dp = 1'b1;
                exp_d = dp && !(ip && starve_m == SL);
            end else begin
                dp = 1'b1;
                ip = 1'b1;
                exp_d = (exp_str[g] == "D");
            end
            d_req = dp; d_we = $urandom_range(0, 1); d_sz = 2'd2;
            d_addr = $urandom & 32'hFFFF_FFFC; d_wdata = $urandom;
            i_req = ip; i_addr = $urandom & 32'hFFFF_FFFC; i_kill = 1'b0;
            bus_ack = 1'b1;
            bus_rdata = $urandom;
            tick();
            at_neg();
            chk("grant_data", d_ack, exp_d);
            chk("grant_fetch", i_ack, !exp_d);
            if (exp_d) begin
                starve_m = ip ? starve_m + 1 : 0;
                dp = 1'b0;
            end else begin
                starve_m = 0;
                ip = 1'b0;
            end
            tick();
        end
        d_req = 1'b0; i_req = 1'b0; bus_ack = 1'b0;
        tick();
    endtask

    initial begin
        int ack_at, kill_at, term;
        bit is_data;
        logic [31:0] a;

        rst = 1'b1;
        d_req = 0; d_we = 0; d_sz = 0; d_addr = 0; d_wdata = 0;
        i_req = 0; i_addr = 0; i_kill = 0; bus_ack = 0; bus_rdata = 0;
        repeat (3) tick();
        at_neg();
        chk("rst_bus", {bus_req, bus_we, bus_be}, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_acks", {d_ack, d_err, i_ack, i_err}, 0);
        chk("rst_rdata", d_rdata | i_rdata, 0);
        tick();
        rst = 1'b0;
        tick();

        // Store byte at 0x1003 acknowledged three cycles into the bus cycle.
        do_access(1'b1, 1'b1, 2'd0, 32'h0000_1003, 32'hABAB_ABAB, 3, 32'h0, -1);
        // Misaligned word.
        do_access(1'b1, 1'b0, 2'd2, 32'h0000_2002, 32'h0, 0, 32'h0, -1);
        // Fetch with no slave response.
        do_access(1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0, 100, 32'h0, -1);
        // Fetch killed one cycle in, then a data load must be granted.
        do_access(1'b0, 1'b0, 2'd2, 32'h0000_0300, 32'h0, 4, 32'h1234_5678, 1);
        do_access(1'b1, 1'b0, 2'd2, 32'h0000_0500, 32'h0, 0, 32'h5555_AAAA, -1);
        // Half store timeout and a size-3 access.
        do_access(1'b1, 1'b1, 2'd1, 32'h0000_0602, 32'hBEEF_BEEF, 20, 32'h0, -1);
        do_access(1'b1, 1'b0, 2'd3, 32'h0000_0703, 32'h0, 7, 32'hCAFE_F00D, -1);

        contention(10, 1'b0);

        // Reset in the middle of a data bus cycle.
        d_req = 1'b1; d_we = 1'b1; d_sz = 2'd2; d_addr = 32'h40; d_wdata = 32'h9999_0000;
        bus_ack = 1'b0;
        tick();
        tick();
        at_neg();
        chk("midrst_busreq_before", bus_req, 1);
        rst = 1'b1;
        d_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus_ack = 1'b1;
        bus_rdata = 32'h7777_7777;
        at_neg();
        chk("midrst_bus", {bus_req, bus_we, bus_be}, 0);
        chk("midrst_addr", bus_addr, 0);
        chk("midrst_wdata", bus_wdata, 0);
        chk("midrst_acks", {d_ack, d_err, i_ack, i_err}, 0);
        chk("midrst_rdata", d_rdata | i_rdata, 0);
        tick();
        bus_ack = 1'b0;
        at_neg();
        check_quiet("midrst_late_ack");
        tick();

        for (int t = 0; t < 60; t++) begin
            is_data = $urandom_range(0, 1);
            ack_at = $urandom_range(0, 10);
            term = (ack_at > TO - 1) ? TO - 1 : ack_at;
            kill_at = -1;
            if (!is_data && term > 0 && $urandom_range(0, 2) == 0) kill_at = $urandom_range(0, term - 1);
            a = $urandom;
            if (!is_data) a = a & 32'hFFFF_FFFC;
            do_access(is_data, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a,
                      $urandom, ack_at, $urandom, kill_at);
            repeat ($urandom_range(0, 2)) tick();
        end

        contention(40, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
